// File: rtl/smg_scan_scheduler.sv
// Scan scheduler for a 4-digit 7-segment display with frame-synchronous load.
// Optional per-slot dimming is enabled by defining SMG_DIMMING_EN.
module smg_scan_scheduler #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] Number_Sig,
    input  logic        Load_Req,
    output logic        Load_Ack,
    input  logic        Zero_Blank_En,
`ifdef SMG_DIMMING_EN
    input  logic [1:0]  Bright,
`endif
    output logic [3:0]  Number_Data,
    output logic [3:0]  Digit_Sel,
    output logic        Blank,
    output logic        Frame_Done
);

    localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    idx_q;
    logic [1:0]    idx_nxt;
    logic [15:0]   shadow_q;
    logic [15:0]   shadow_nxt;
    logic          zb_q;
    logic          zb_nxt;
    logic          last;
    logic          boundary;
    logic          load;
    phase_t        phase_nxt;
    logic [3:0]    nib_nxt;
    logic          sup_nxt;
    logic          lit_nxt;
    logic          show_nxt;
    logic [3:0]    sel_nxt;

`ifdef SMG_DIMMING_EN
    localparam int SHOW_LEN = DWELL_CYCLES - BLANK_CYCLES;
    localparam logic [CW:0] LIM0 = (CW+1)'(BLANK_CYCLES + (SHOW_LEN * 1) / 4);
    localparam logic [CW:0] LIM1 = (CW+1)'(BLANK_CYCLES + (SHOW_LEN * 2) / 4);
    localparam logic [CW:0] LIM2 = (CW+1)'(BLANK_CYCLES + (SHOW_LEN * 3) / 4);
    localparam logic [CW:0] LIM3 = (CW+1)'(DWELL_CYCLES);

    logic [1:0]  bright_q;
    logic [1:0]  bright_nxt;
    logic [CW:0] lim;

    always_comb begin
        bright_nxt = (cnt_nxt == '0) ? Bright : bright_q;
        lim = LIM3;
        unique case (bright_nxt)
            2'd0: lim = LIM0;
            2'd1: lim = LIM1;
            2'd2: lim = LIM2;
            2'd3: lim = LIM3;
        endcase
        lit_nxt = ({1'b0, cnt_nxt} < lim);
    end

    always_ff @(posedge CLK) begin
        if (RST) bright_q <= Bright;
        else     bright_q <= bright_nxt;
    end
`else
    assign lit_nxt = 1'b1;
`endif

    // Outputs are computed from next-state values so they land with the counter.
    always_comb begin
        last = (cnt_q == LAST);
        boundary = last && (idx_q == 2'd0);
        load = boundary && Load_Req;
        cnt_nxt = last ? '0 : cnt_q + 1'b1;
        idx_nxt = last ? idx_q - 2'd1 : idx_q;
        shadow_nxt = load ? Number_Sig : shadow_q;
        zb_nxt = (cnt_nxt == '0) ? Zero_Blank_En : zb_q;
        phase_nxt = (cnt_nxt < BLANK_END) ? PH_BLANK : PH_SHOW;
        nib_nxt = 4'h0;
        sup_nxt = 1'b0;
        unique case (idx_nxt)
            2'd3: begin
                nib_nxt = shadow_nxt[15:12];
                sup_nxt = (shadow_nxt[15:12] == 4'h0);
            end
            2'd2: begin
                nib_nxt = shadow_nxt[11:8];
                sup_nxt = (shadow_nxt[15:8] == 8'h0);
            end
            2'd1: begin
                nib_nxt = shadow_nxt[7:4];
                sup_nxt = (shadow_nxt[15:4] == 12'h0);
            end
            2'd0: begin
                nib_nxt = shadow_nxt[3:0];
                sup_nxt = 1'b0;
            end
        endcase
        show_nxt = (phase_nxt == PH_SHOW) && !(zb_nxt && sup_nxt) && lit_nxt;
        sel_nxt = show_nxt ? ~(4'b0001 << idx_nxt) : 4'hF;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q       <= '0;
            idx_q       <= 2'd3;
            shadow_q    <= 16'h0;
            zb_q        <= Zero_Blank_En;
            Number_Data <= 4'h0;
            Digit_Sel   <= 4'hF;
            Blank       <= 1'b1;
            Load_Ack    <= 1'b0;
            Frame_Done  <= 1'b0;
        end else begin
            cnt_q       <= cnt_nxt;
            idx_q       <= idx_nxt;
            shadow_q    <= shadow_nxt;
            zb_q        <= zb_nxt;
            Number_Data <= nib_nxt;
            Digit_Sel   <= sel_nxt;
            Blank       <= !show_nxt;
            Load_Ack    <= load;
            Frame_Done  <= boundary;
        end
    end

endmodule

// File: tb/tb_smg_scan_scheduler.sv
// Directed bench for smg_scan_scheduler (DWELL=20, BLANK=4).
module tb_smg_scan_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] Number_Sig = 16'h0;
    logic        Load_Req = 1'b0;
    logic        Load_Ack;
    logic        Zero_Blank_En = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic [3:0]  Number_Data;
    logic [3:0]  Digit_Sel;
    logic        Blank;
    logic        Frame_Done;

    int n_tests = 0;
    int n_fail = 0;

    smg_scan_scheduler #(
        .DWELL_CYCLES(20),
        .BLANK_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .Number_Sig(Number_Sig),
        .Load_Req(Load_Req),
        .Load_Ack(Load_Ack),
        .Zero_Blank_En(Zero_Blank_En),
`ifdef SMG_DIMMING_EN
        .Bright(bright),
`endif
        .Number_Data(Number_Data),
        .Digit_Sel(Digit_Sel),
        .Blank(Blank),
        .Frame_Done(Frame_Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] num;
        logic        zb;
        logic [15:0] sel;
        logic [3:0]  blk;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {23'h0, Number_Data, Digit_Sel, Blank};
    endfunction

    initial begin
        logic early;
        logic ok;
        int   s;
        int   o;
        int   d;

        tbl[0] = '{16'h1234, 1'b0, 16'h7BDE, 4'b0000};
        tbl[1] = '{16'hABCD, 1'b0, 16'h7BDE, 4'b0000};
        tbl[2] = '{16'h0005, 1'b1, 16'hFFFE, 4'b1110};
        tbl[3] = '{16'h0000, 1'b1, 16'hFFFE, 4'b1110};
        tbl[4] = '{16'h0040, 1'b1, 16'hFFDE, 4'b1100};
        tbl[5] = '{16'h0000, 1'b0, 16'h7BDE, 4'b0000};
        tbl[6] = '{16'h0305, 1'b1, 16'hFBDE, 4'b1000};

        repeat (3) tick();
        chk("reset_outputs", {outs(), 2'b00} | {Load_Ack, Frame_Done},
            {23'h0, 4'h0, 4'hF, 1'b1, 2'b00});
        RST = 1'b0;

        early = 1'b0;
        for (int t = 1; t < 80; t++) begin
            tick();
            if (Load_Ack || Frame_Done) early = 1'b1;
            if (t == 3) chk("first_blank", outs(), {23'h0, 4'h0, 4'hF, 1'b1});
            if (t == 4) chk("first_show", outs(), {23'h0, 4'h0, 4'h7, 1'b0});
            if (t == 40) begin
                Number_Sig = tbl[0].num;
                Load_Req = 1'b1;
            end
        end
        chk("no_early_pulse", 32'(early), 32'd0);

        for (int r = 0; r < 7; r++) begin
            ok = 1'b0;
            for (int w = 0; w < 200; w++) begin
                tick();
                if (Load_Ack) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk($sformatf("ack_seen_%0d", r), 32'(ok), 32'd1);
            chk($sformatf("ack_with_frame_%0d", r), 32'(Frame_Done), 32'd1);
            Load_Req = 1'b0;
            chk($sformatf("predrive_%0d", r), outs(),
                {23'h0, tbl[r].num[15:12], 4'hF, 1'b1});
            for (int p = 1; p < 80; p++) begin
                tick();
                if (p == 1)
                    chk($sformatf("pulse_width_%0d", r),
                        {30'h0, Load_Ack, Frame_Done}, 32'd0);
                s = p / 20;
                o = p % 20;
                d = 3 - s;
                if (o == 3)
                    chk($sformatf("r%0d_d%0d_gap", r, d), outs(),
                        {23'h0, tbl[r].num[d*4 +: 4], 4'hF, 1'b1});
                if (o == 4 || o == 19)
                    chk($sformatf("r%0d_d%0d_o%0d", r, d, o), outs(),
                        {23'h0, tbl[r].num[d*4 +: 4], tbl[r].sel[d*4 +: 4],
                         tbl[r].blk[d]});
                if (p == 40) begin
                    Number_Sig = (r < 6) ? tbl[(r + 1) % 7].num : 16'hFFFF;
                    Load_Req = 1'b1;
                end
                if (p == 45 && r == 6) Load_Req = 1'b0;
                if (p == 79 && r < 6) Zero_Blank_En = tbl[r + 1].zb;
            end
        end

        tick();
        chk("dropped_req_no_ack", {30'h0, Load_Ack, Frame_Done}, 32'd1);
        for (int p = 1; p <= 50; p++) begin
            tick();
            if (p == 4) chk("kept_d3_sup", outs(), {23'h0, 4'h0, 4'hF, 1'b1});
            if (p == 24) chk("kept_d2", outs(), {23'h0, 4'h3, 4'hB, 1'b0});
            if (p == 50) chk("kept_d1", outs(), {23'h0, 4'h0, 4'hD, 1'b0});
        end

        Number_Sig = 16'h9999;
        Load_Req = 1'b1;
        Zero_Blank_En = 1'b0;
        RST = 1'b1;
        tick();
        chk("reset_mid_slot", {outs(), 2'b00} | {Load_Ack, Frame_Done},
            {23'h0, 4'h0, 4'hF, 1'b1, 2'b00});
        tick();
        Load_Req = 1'b0;
        RST = 1'b0;
        early = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (Load_Ack) early = 1'b1;
            if (t == 4) chk("shadow_cleared", outs(), {23'h0, 4'h0, 4'h7, 1'b0});
        end
        chk("no_ack_after_reset", 32'(early), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
